// File: rtl/wb_obi_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-OBI bridge.
`timescale 1ns/1ps
package wb_obi_bridge_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Bridge sequencing: accept WB transfer, hold OBI request, wait for response,
  // pulse ack, or absorb a late response after a timeout.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    ACK,
    DRAIN
  } state_t;

  // Counter width able to hold 0..timeout_cycles, never narrower than one bit.
  function automatic int timeout_cnt_w(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// Response timeout counter: counts enabled cycles and flags the terminal count.
`timescale 1ns/1ps
module bridge_timeout_cnt
  import wb_obi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Cycle counter: clear wins over enable; holds when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal count only matters while the bridge is actually waiting.
  assign done = enable && (count == TERM);

endmodule

// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI master bridge: one WB transfer -> one OBI transaction,
// with a response timeout so a silent OBI slave cannot hang the Wishbone bus.
`timescale 1ns/1ps
module wb_obi_bridge
  import wb_obi_bridge_pkg::*;
#(
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter int                DATA_W          = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] OBI_ADDR_OFFSET = '0,
  parameter int                TIMEOUT_CYCLES  = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_wdata_i,
  input  logic                wb_wr_en_i,
  input  logic [DATA_W/8-1:0] wb_byte_en_i,
  output logic [DATA_W-1:0]   wb_rdata_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [ADDR_W-1:0]   obi_addr_o,
  output logic                obi_wr_en_o,
  output logic [DATA_W/8-1:0] obi_byte_en_o,
  output logic [DATA_W-1:0]   obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [DATA_W-1:0]   obi_rdata_i
);

  state_t state;
  logic   abort_q;
  logic   abort_now;
  logic   tmo_hit;

  // A master that drops cyc in the response cycle itself is treated as gone too.
  assign abort_now = abort_q || !wb_cyc_i;

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      logic cnt_clear;
      logic cnt_enable;

      // Restart on grant; count only cycles spent waiting without a response.
      assign cnt_clear  = (state == REQ) && obi_gnt_i;
      assign cnt_enable = (state == RESP) && !obi_rvalid_i;

      bridge_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .done   (tmo_hit)
      );
    end else begin : g_no_timeout
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // Bridge FSM with all bus outputs registered in the same block.
  // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      abort_q       <= 1'b0;
      wb_rdata_o    <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      obi_req_o     <= 1'b0;
      obi_addr_o    <= '0;
      obi_wr_en_o   <= 1'b0;
      obi_byte_en_o <= '0;
      obi_wdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            obi_addr_o    <= wb_addr_i + OBI_ADDR_OFFSET;
            obi_wdata_o   <= wb_wdata_i;
            obi_wr_en_o   <= wb_wr_en_i;
            obi_byte_en_o <= wb_byte_en_i;
            obi_req_o     <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          // The request is never withdrawn; a vanished master only marks the abort.
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state     <= RESP;
          end
        end

        RESP: begin
          if (obi_rvalid_i) begin
            wb_rdata_o <= obi_rdata_i;
            if (abort_now) begin
              abort_q <= 1'b0;
              state   <= IDLE;
            end else begin
              wb_ack_o <= 1'b1;
              state    <= ACK;
            end
          end else begin
            if (!wb_cyc_i) begin
              abort_q <= 1'b1;
            end
            if (tmo_hit) begin
              wb_err_o <= !abort_now;
              state    <= DRAIN;
            end
          end
        end

        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end

        DRAIN: begin
          // The late response is swallowed; no new WB request is taken meanwhile.
          wb_err_o <= 1'b0;
          if (obi_rvalid_i) begin
            abort_q <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Self-checking bench for wb_obi_bridge: per-scenario tasks plus a response scoreboard.
`timescale 1ns/1ps
module tb_wb_obi_bridge;

  logic        clk;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_wr_en_i;
  logic [31:0] wb_addr_i, wb_wdata_i;
  logic [3:0]  wb_byte_en_i;
  logic [31:0] wb_rdata_o;
  logic        wb_ack_o, wb_err_o;
  logic        obi_req_o, obi_gnt_i, obi_wr_en_o, obi_rvalid_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0]  obi_byte_en_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  wb_obi_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .OBI_ADDR_OFFSET(32'h8000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_addr_i(wb_addr_i),
    .wb_wdata_i(wb_wdata_i),
    .wb_wr_en_i(wb_wr_en_i),
    .wb_byte_en_i(wb_byte_en_i),
    .wb_rdata_o(wb_rdata_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .obi_req_o(obi_req_o),
    .obi_gnt_i(obi_gnt_i),
    .obi_addr_o(obi_addr_o),
    .obi_wr_en_o(obi_wr_en_o),
    .obi_byte_en_o(obi_byte_en_o),
    .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i(obi_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every ack/err pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (wb_ack_o || wb_err_o)) begin
      n_total++;
      if (wb_ack_o && wb_err_o) begin
        $display("FAIL sb_excl: ack=%b err=%b both high", wb_ack_o, wb_err_o);
      end else if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: ack=%b err=%b with no response expected", wb_ack_o, wb_err_o);
      end else begin
        e = sb.pop_front();
        if (wb_err_o !== e.is_err || (e.chk && wb_rdata_o !== e.data))
          $display("FAIL sb_resp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   wb_err_o, wb_rdata_o, e.is_err, e.data);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 0; wb_stb_i = 0; wb_wr_en_i = 0;
    wb_addr_i = '0; wb_wdata_i = '0; wb_byte_en_i = '0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0;
  endtask

  task automatic wb_start(input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be);
    wb_cyc_i = 1; wb_stb_i = 1; wb_addr_i = addr;
    wb_wr_en_i = we; wb_wdata_i = wdata; wb_byte_en_i = be;
  endtask

  task automatic push_exp(input logic is_err, input logic chk, input logic [31:0] data);
    exp_t e;
    e.is_err = is_err; e.chk = chk; e.data = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1;
    bus_idle();
    #2;
    n_total++; if ({obi_req_o, wb_ack_o, wb_err_o, obi_wr_en_o} !== 4'b0)
      $display("FAIL rst_ctrl: got %b expected 0000", {obi_req_o, wb_ack_o, wb_err_o, obi_wr_en_o}); else n_pass++;
    step(); step();
    n_total++; if ({wb_rdata_o, obi_addr_o, obi_wdata_o, obi_byte_en_o} !== 100'b0)
      $display("FAIL rst_data: rdata=%h addr=%h wdata=%h be=%h expected 0", wb_rdata_o, obi_addr_o, obi_wdata_o, obi_byte_en_o); else n_pass++;
    rst = 0;
    step();
  endtask

  task automatic test_read_offset();
    wb_start(32'h0000_0010, 0, '0, 4'hF);
    push_exp(0, 1, 32'hDEAD_BEEF);
    step(); // cycle 1
    n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h8000_0010 || obi_wr_en_o !== 1'b0 || obi_byte_en_o !== 4'hF)
      $display("FAIL rd_addr_phase: req=%b addr=%h we=%b be=%h expected 1 80000010 0 f", obi_req_o, obi_addr_o, obi_wr_en_o, obi_byte_en_o); else n_pass++;
    obi_gnt_i = 1;
    step(); // cycle 2
    n_total++; if (obi_req_o !== 1'b0) $display("FAIL rd_req_drop: got %b expected 0", obi_req_o); else n_pass++;
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'hDEAD_BEEF;
    step(); // cycle 3
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b1 || wb_rdata_o !== 32'hDEAD_BEEF)
      $display("FAIL rd_latency: ack=%b rdata=%h expected 1 deadbeef", wb_ack_o, wb_rdata_o); else n_pass++;
    bus_idle();
    step(); // cycle 4
    n_total++; if (wb_ack_o !== 1'b0) $display("FAIL rd_ack_pulse: got %b expected 0", wb_ack_o); else n_pass++;
  endtask

  task automatic test_write_gnt_delay();
    wb_start(32'h0000_0020, 1, 32'hA5A5_5A5A, 4'b0101);
    push_exp(0, 0, '0);
    step(); // cycle 1
    for (int i = 1; i <= 5; i++) begin
      n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h8000_0020 || obi_wdata_o !== 32'hA5A5_5A5A
                     || obi_byte_en_o !== 4'b0101 || obi_wr_en_o !== 1'b1)
        $display("FAIL wr_hold_c%0d: req=%b addr=%h wdata=%h be=%b we=%b expected 1 80000020 a5a55a5a 0101 1",
                 i, obi_req_o, obi_addr_o, obi_wdata_o, obi_byte_en_o, obi_wr_en_o); else n_pass++;
      if (i == 5) obi_gnt_i = 1;
      step();
    end
    obi_gnt_i = 0; // cycle 6
    n_total++; if (obi_req_o !== 1'b0 || wb_ack_o !== 1'b0)
      $display("FAIL wr_after_gnt: req=%b ack=%b expected 0 0", obi_req_o, wb_ack_o); else n_pass++;
    step(); // cycle 7
    obi_rvalid_i = 1;
    step(); // cycle 8
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b1) $display("FAIL wr_ack: got %b expected 1", wb_ack_o); else n_pass++;
    bus_idle();
    step();
  endtask

  task automatic test_timeout();
    wb_start(32'h0000_0040, 0, '0, 4'hF);
    push_exp(1, 0, '0);
    step(); // cycle 1
    obi_gnt_i = 1;
    step(); // cycle 2
    obi_gnt_i = 0;
    for (int i = 2; i <= 9; i++) begin
      n_total++; if (wb_err_o !== 1'b0 || obi_req_o !== 1'b0)
        $display("FAIL to_wait_c%0d: err=%b req=%b expected 0 0", i, wb_err_o, obi_req_o); else n_pass++;
      step();
    end
    n_total++; if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0)
      $display("FAIL to_err: err=%b ack=%b expected 1 0", wb_err_o, wb_ack_o); else n_pass++;
    bus_idle();
    step(); // cycle 11
    n_total++; if (wb_err_o !== 1'b0) $display("FAIL to_err_pulse: got %b expected 0", wb_err_o); else n_pass++;
    step(); // cycle 12: new request while draining
    wb_start(32'h0000_0044, 0, '0, 4'hF);
    push_exp(0, 1, 32'h1234_5678);
    for (int i = 12; i <= 19; i++) begin
      n_total++; if (obi_req_o !== 1'b0) $display("FAIL to_drain_c%0d: req=%b expected 0", i, obi_req_o); else n_pass++;
      step();
    end
    obi_rvalid_i = 1; obi_rdata_i = 32'hBAD0_BAD0; // cycle 20: late response
    step(); // cycle 21
    obi_rvalid_i = 0;
    n_total++; if (obi_req_o !== 1'b0) $display("FAIL to_drain_exit: req=%b expected 0", obi_req_o); else n_pass++;
    step(); // cycle 22
    n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h8000_0044)
      $display("FAIL to_next_req: req=%b addr=%h expected 1 80000044", obi_req_o, obi_addr_o); else n_pass++;
    obi_gnt_i = 1;
    step();
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'h1234_5678;
    step();
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b1) $display("FAIL to_next_ack: got %b expected 1", wb_ack_o); else n_pass++;
    bus_idle();
    step();
  endtask

  task automatic test_abort();
    wb_start(32'h0000_0080, 0, '0, 4'hF);
    step(); // cycle 1
    bus_idle(); // master gives up while request pending
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) begin
        n_total++; if (obi_req_o !== 1'b1) $display("FAIL ab_req_hold_c%0d: got %b expected 1", i, obi_req_o); else n_pass++;
      end
      if (i == 3) obi_gnt_i = 1;
      step();
    end
    obi_gnt_i = 0; // cycle 4
    n_total++; if (obi_req_o !== 1'b0) $display("FAIL ab_req_drop: got %b expected 0", obi_req_o); else n_pass++;
    step();
    obi_rvalid_i = 1; obi_rdata_i = 32'hFACE_FACE; // cycle 5
    step(); // cycle 6
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0)
      $display("FAIL ab_no_resp: ack=%b err=%b expected 0 0", wb_ack_o, wb_err_o); else n_pass++;
    wb_start(32'h0000_0084, 0, '0, 4'hF);
    push_exp(0, 1, 32'h0000_0084);
    step(); // cycle 7
    n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h8000_0084)
      $display("FAIL ab_idle_again: req=%b addr=%h expected 1 80000084", obi_req_o, obi_addr_o); else n_pass++;
    obi_gnt_i = 1;
    step();
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'h0000_0084;
    step();
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b1) $display("FAIL ab_next_ack: got %b expected 1", wb_ack_o); else n_pass++;
    bus_idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      d = 32'hC0DE_0000 | 32'(k);
      wb_start(32'h0000_0200 + 32'(4 * k), 0, '0, 4'hF);
      push_exp(0, 1, d);
      step(); // 4k+1
      n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== (32'h8000_0200 + 32'(4 * k)))
        $display("FAIL b2b_req_%0d: req=%b addr=%h expected 1 %h", k, obi_req_o, obi_addr_o, 32'h8000_0200 + 32'(4 * k)); else n_pass++;
      obi_gnt_i = 1;
      step(); // 4k+2
      obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = d;
      step(); // 4k+3
      obi_rvalid_i = 0;
      n_total++; if (wb_ack_o !== 1'b1 || wb_rdata_o !== d)
        $display("FAIL b2b_ack_%0d: ack=%b rdata=%h expected 1 %h", k, wb_ack_o, wb_rdata_o, d); else n_pass++;
      step(); // 4k+4
      n_total++; if (wb_ack_o !== 1'b0) $display("FAIL b2b_gap_%0d: ack=%b expected 0", k, wb_ack_o); else n_pass++;
    end
    bus_idle();
    step();
  endtask

  task automatic test_reset_mid();
    wb_start(32'h0000_0100, 1, 32'h5555_AAAA, 4'hC);
    push_exp(0, 0, '0);
    step();
    obi_gnt_i = 1;
    step(); // in RESP
    obi_gnt_i = 0;
    #2 rst = 1;
    #1;
    n_total++; if ({obi_req_o, wb_ack_o, wb_err_o, obi_wr_en_o} !== 4'b0 || wb_rdata_o !== '0
                   || obi_addr_o !== '0 || obi_wdata_o !== '0 || obi_byte_en_o !== '0)
      $display("FAIL rstmid_outs: req=%b ack=%b err=%b we=%b rdata=%h addr=%h wdata=%h be=%h expected all 0",
               obi_req_o, wb_ack_o, wb_err_o, obi_wr_en_o, wb_rdata_o, obi_addr_o, obi_wdata_o, obi_byte_en_o); else n_pass++;
    sb.delete(); // the interrupted transfer never completes
    bus_idle();
    #2 rst = 0;
    step();
    wb_start(32'h0000_0104, 0, '0, 4'hF);
    push_exp(0, 1, 32'h600D_F00D);
    step();
    n_total++; if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h8000_0104)
      $display("FAIL rstmid_req: req=%b addr=%h expected 1 80000104", obi_req_o, obi_addr_o); else n_pass++;
    obi_gnt_i = 1;
    step();
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'h600D_F00D;
    step();
    obi_rvalid_i = 0;
    n_total++; if (wb_ack_o !== 1'b1 || wb_rdata_o !== 32'h600D_F00D)
      $display("FAIL rstmid_read: ack=%b rdata=%h expected 1 600df00d", wb_ack_o, wb_rdata_o); else n_pass++;
    bus_idle();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read_offset();
    test_write_gnt_delay();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_total++; if (sb.size() != 0)
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
